// File: rtl/event_ba_filter.sv
// Background-activity filter: an address event passes only when a spatial neighbour fired within win ticks.
// Build option EVT_FILT_STATS_EN adds a saturating drop_cnt output.
module event_ba_filter #(
  parameter int X_W = 2,
  parameter int Y_W = 2,
  parameter int P_W = 2,
  parameter int T_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [P_W-1:0] p,
  input  logic [T_W-1:0] t,
  input  logic [T_W-1:0] win,
  input  logic           bypass,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic [P_W-1:0] p_out,
  output logic [T_W-1:0] t_out
`ifdef EVT_FILT_STATS_EN
  ,
  output logic [15:0]    drop_cnt
`endif
);

  localparam int NCELL = 1 << (X_W + Y_W);
  localparam logic [X_W:0] X_ONE = 1;
  localparam logic [Y_W:0] Y_ONE = 1;

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE, EMIT} state_t;

  state_t                 state, state_nxt;
  logic [T_W-1:0]         ts_mem [NCELL];
  logic [NCELL-1:0]       vld_mem;
  logic [T_W-1:0]         win_l;
  logic                   byp_l, pass;
  logic [2:0]             idx;
  logic [X_W:0]           nx_e;
  logic [Y_W:0]           ny_e;
  logic [X_W+Y_W-1:0]     n_addr, own_addr;
  logic [T_W-1:0]         age;
  logic                   n_in, hit;

  // Neighbour offset for the current scan index; the extra top bit flags off-array.
  always_comb begin
    nx_e = {1'b0, x_out};
    ny_e = {1'b0, y_out};
    case (idx)
      3'd0, 3'd3, 3'd5: nx_e = {1'b0, x_out} - X_ONE;
      3'd2, 3'd4, 3'd7: nx_e = {1'b0, x_out} + X_ONE;
      default: ;
    endcase
    case (idx)
      3'd0, 3'd1, 3'd2: ny_e = {1'b0, y_out} - Y_ONE;
      3'd5, 3'd6, 3'd7: ny_e = {1'b0, y_out} + Y_ONE;
      default: ;
    endcase
  end

  assign n_addr   = {ny_e[Y_W-1:0], nx_e[X_W-1:0]};
  assign own_addr = {y_out, x_out};
  assign n_in     = !nx_e[X_W] && !ny_e[Y_W];
  assign age      = t_out - ts_mem[n_addr];
  // Bypass is resolved as a forced hit on the first scan slot, keeping its latency equal to an idx-0 hit.
  assign hit      = byp_l || (n_in && vld_mem[n_addr] && (age <= win_l));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SCAN;
      end
      SCAN:   if (hit || idx == 3'd7) state_nxt = UPDATE;
      UPDATE: state_nxt = pass ? EMIT : IDLE;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x_out   <= '0;
      y_out   <= '0;
      p_out   <= '0;
      t_out   <= '0;
      win_l   <= '0;
      byp_l   <= 1'b0;
      pass    <= 1'b0;
      idx     <= '0;
      vld_mem <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          x_out <= x;
          y_out <= y;
          p_out <= p;
          t_out <= t;
          win_l <= win;
          byp_l <= bypass;
          pass  <= 1'b0;
          idx   <= '0;
        end
        SCAN: begin
          pass <= hit;
          idx  <= idx + 3'd1;
        end
        UPDATE: vld_mem[own_addr] <= 1'b1;
        default: ;
      endcase
    end
  end

  // Timestamps need no reset: an entry is only read when its vld bit is set.
  always_ff @(posedge clk) begin
    if (state == UPDATE) ts_mem[own_addr] <= t_out;
  end

`ifdef EVT_FILT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (state == UPDATE && !pass && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule
